// File: rtl/z_core_decode_stage.sv
// Z-Core RV32I decode stage: decodes one instruction into ALU operands, op code and control.
// Optional performance counters are enabled with the macro Z_CORE_DECODE_PERF_EN.
module z_core_decode_stage #(
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_alu_in1,
  output logic [31:0] ex_alu_in2,
  output logic [3:0]  ex_alu_inst_type,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_we,
  output logic        ex_mem_rd,
  output logic        ex_mem_wr,
  output logic [2:0]  ex_funct3,
  output logic [31:0] ex_store_data,
  output logic        ex_is_branch,
  output logic        ex_is_jump,
  output logic [31:0] ex_target,
`ifdef Z_CORE_DECODE_PERF_EN
  output logic        ex_illegal,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`else
  output logic        ex_illegal
`endif
);

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_BEQ = 4'd10, ALU_BNE = 4'd11,
    ALU_BLT = 4'd12, ALU_BGE = 4'd13, ALU_BLTU = 4'd14, ALU_BGEU = 4'd15
  } alu_op_e;

  // Reserved parameter; elaborates to nothing.
  if (RESET_PC_UNUSED != 0) begin : g_reserved
  end

  function automatic alu_op_e alu_op_of_funct3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e branch_op_of_funct3(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_BEQ;
      3'd1:    return ALU_BNE;
      3'd4:    return ALU_BLT;
      3'd5:    return ALU_BGE;
      3'd6:    return ALU_BLTU;
      default: return ALU_BGEU;
    endcase
  endfunction

  // ---- stage p0: combinational decode of the incoming instruction ----
  logic [6:0]               opcode_p0;
  logic [2:0]               funct3_p0;
  logic [6:0]               funct7_p0;
  logic [4:0]               rd_p0;
  logic signed [DATA_W-1:0] imm_i_p0, imm_s_p0, imm_b_p0, imm_u_p0, imm_j_p0;
  logic [DATA_W-1:0]        jalr_sum_p0;
  logic [DATA_W-1:0]        alu_in1_p0, alu_in2_p0, store_data_p0, target_p0;
  alu_op_e                  alu_op_p0;
  logic                     reg_we_p0, mem_rd_p0, mem_wr_p0;
  logic                     is_branch_p0, is_jump_p0, illegal_p0;
  logic                     take_p0, load_p0;

  assign opcode_p0 = if_instr[6:0];
  assign funct3_p0 = if_instr[14:12];
  assign funct7_p0 = if_instr[31:25];
  assign rd_p0     = if_instr[11:7];
  assign rs1_addr  = if_instr[19:15];
  assign rs2_addr  = if_instr[24:20];

  assign imm_i_p0 = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s_p0 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b_p0 = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                     if_instr[11:8], 1'b0};
  assign imm_u_p0 = {if_instr[31:12], 12'b0};
  assign imm_j_p0 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                     if_instr[30:21], 1'b0};
  assign jalr_sum_p0 = rs1_data + imm_i_p0;

  always_comb begin
    alu_in1_p0    = '0;
    alu_in2_p0    = '0;
    alu_op_p0     = ALU_ADD;
    reg_we_p0     = 1'b0;
    mem_rd_p0     = 1'b0;
    mem_wr_p0     = 1'b0;
    is_branch_p0  = 1'b0;
    is_jump_p0    = 1'b0;
    target_p0     = '0;
    store_data_p0 = '0;
    illegal_p0    = 1'b0;
    case (opcode_p0)
      OPC_OP: begin
        alu_in1_p0 = rs1_data;
        alu_in2_p0 = rs2_data;
        reg_we_p0  = 1'b1;
        if (funct7_p0 == 7'h00)                           alu_op_p0 = alu_op_of_funct3(funct3_p0);
        else if (funct7_p0 == 7'h20 && funct3_p0 == 3'd0) alu_op_p0 = ALU_SUB;
        else if (funct7_p0 == 7'h20 && funct3_p0 == 3'd5) alu_op_p0 = ALU_SRA;
        else                                              illegal_p0 = 1'b1;
      end
      OPC_OPIMM: begin
        alu_in1_p0 = rs1_data;
        alu_in2_p0 = imm_i_p0;
        reg_we_p0  = 1'b1;
        alu_op_p0  = alu_op_of_funct3(funct3_p0);
        // Shift immediates reuse imm[11:5] as a funct7 selector.
        if (funct3_p0 == 3'd1 && funct7_p0 != 7'h00) illegal_p0 = 1'b1;
        if (funct3_p0 == 3'd5) begin
          if (funct7_p0 == 7'h20)      alu_op_p0 = ALU_SRA;
          else if (funct7_p0 != 7'h00) illegal_p0 = 1'b1;
        end
      end
      OPC_LUI: begin
        alu_in2_p0 = imm_u_p0;
        reg_we_p0  = 1'b1;
      end
      OPC_AUIPC: begin
        alu_in1_p0 = if_pc;
        alu_in2_p0 = imm_u_p0;
        reg_we_p0  = 1'b1;
      end
      OPC_JAL: begin
        alu_in1_p0 = if_pc;
        alu_in2_p0 = 32'd4;
        reg_we_p0  = 1'b1;
        is_jump_p0 = 1'b1;
        target_p0  = if_pc + imm_j_p0;
      end
      OPC_JALR: begin
        alu_in1_p0 = if_pc;
        alu_in2_p0 = 32'd4;
        reg_we_p0  = 1'b1;
        is_jump_p0 = 1'b1;
        target_p0  = {jalr_sum_p0[31:1], 1'b0};
        illegal_p0 = (funct3_p0 != 3'd0);
      end
      OPC_BRANCH: begin
        alu_in1_p0   = rs1_data;
        alu_in2_p0   = rs2_data;
        alu_op_p0    = branch_op_of_funct3(funct3_p0);
        is_branch_p0 = 1'b1;
        target_p0    = if_pc + imm_b_p0;
        illegal_p0   = (funct3_p0 == 3'd2 || funct3_p0 == 3'd3);
      end
      OPC_LOAD: begin
        alu_in1_p0 = rs1_data;
        alu_in2_p0 = imm_i_p0;
        reg_we_p0  = 1'b1;
        mem_rd_p0  = 1'b1;
        illegal_p0 = (funct3_p0 == 3'd3 || funct3_p0 == 3'd6 || funct3_p0 == 3'd7);
      end
      OPC_STORE: begin
        alu_in1_p0    = rs1_data;
        alu_in2_p0    = imm_s_p0;
        mem_wr_p0     = 1'b1;
        store_data_p0 = rs2_data;
        illegal_p0    = (funct3_p0 > 3'd2);
      end
      default: illegal_p0 = 1'b1;
    endcase
    if (illegal_p0) begin
      alu_in1_p0    = '0;
      alu_in2_p0    = '0;
      alu_op_p0     = ALU_ADD;
      reg_we_p0     = 1'b0;
      mem_rd_p0     = 1'b0;
      mem_wr_p0     = 1'b0;
      is_branch_p0  = 1'b0;
      is_jump_p0    = 1'b0;
      target_p0     = '0;
      store_data_p0 = '0;
    end
    if (rd_p0 == 5'd0) reg_we_p0 = 1'b0;
  end

  assign if_ready = !ex_valid || ex_ready;
  assign take_p0  = if_valid && if_ready;
  assign load_p0  = take_p0 && !flush;

  // ---- stage p1: execute-facing pipeline register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid         <= 1'b0;
      ex_alu_in1       <= '0;
      ex_alu_in2       <= '0;
      ex_alu_inst_type <= '0;
      ex_rd            <= '0;
      ex_reg_we        <= 1'b0;
      ex_mem_rd        <= 1'b0;
      ex_mem_wr        <= 1'b0;
      ex_funct3        <= '0;
      ex_store_data    <= '0;
      ex_is_branch     <= 1'b0;
      ex_is_jump       <= 1'b0;
      ex_target        <= '0;
      ex_illegal       <= 1'b0;
    end else begin
      if (flush)        ex_valid <= 1'b0;
      else if (take_p0) ex_valid <= 1'b1;
      else if (ex_ready) ex_valid <= 1'b0;
      if (load_p0) begin
        ex_alu_in1       <= alu_in1_p0;
        ex_alu_in2       <= alu_in2_p0;
        ex_alu_inst_type <= alu_op_p0;
        ex_rd            <= rd_p0;
        ex_reg_we        <= reg_we_p0;
        ex_mem_rd        <= mem_rd_p0;
        ex_mem_wr        <= mem_wr_p0;
        ex_funct3        <= funct3_p0;
        ex_store_data    <= store_data_p0;
        ex_is_branch     <= is_branch_p0;
        ex_is_jump       <= is_jump_p0;
        ex_target        <= target_p0;
        ex_illegal       <= illegal_p0;
      end
    end
  end

`ifdef Z_CORE_DECODE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (load_p0)               perf_issued <= perf_issued + 32'd1;
      if (ex_valid && !ex_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
